// File: rtl/audio_pkg.sv
// audio_pkg: constants, FSM state encoding and sample-pair type shared by the
// WM8750 DSP-mode-B receiver (audio_adc_rx) and its DAC transmitter counterpart.
//   AUDIO_SAMPLE_W  - bits per channel sample
//   AUDIO_FRAME_LEN - clk12 cycles between frame-sync pulses
//   audio_state_e   - frame FSM states
//   audio_pair_t    - {left, right} sample pair
//   abs_sat()       - magnitude of a signed sample, saturating -32768 to 32767
package audio_pkg;

  localparam int AUDIO_SAMPLE_W  = 16;
  localparam int AUDIO_FRAME_LEN = 256;

  typedef enum logic [2:0] {IDLE, SKIP, SHIFT, LOAD, WAIT} audio_state_e;

  typedef struct packed {
    logic [AUDIO_SAMPLE_W-1:0] left;
    logic [AUDIO_SAMPLE_W-1:0] right;
  } audio_pair_t;

  function automatic logic [AUDIO_SAMPLE_W-1:0] abs_sat(input logic [AUDIO_SAMPLE_W-1:0] s);
    if (s == {1'b1, {(AUDIO_SAMPLE_W-1){1'b0}}})
      return {1'b0, {(AUDIO_SAMPLE_W-1){1'b1}}};
    else if (s[AUDIO_SAMPLE_W-1])
      return -s;
    else
      return s;
  endfunction

endpackage

// File: rtl/audio_peak_meter.sv
// audio_peak_meter: per-channel peak-hold meter with slow decay.
// Only built when AUDIO_ADC_RX_PEAK_EN is defined.
//   clk12, reset12_ - clock, async active-low reset
//   load            - a new sample is presented this cycle
//   sample          - signed two's-complement sample
//   sync            - frame sync pulse (once per frame)
//   peak            - unsigned peak magnitude
module audio_peak_meter
  import audio_pkg::*;
(
  input  logic                      clk12,
  input  logic                      reset12_,
  input  logic                      load,
  input  logic [AUDIO_SAMPLE_W-1:0] sample,
  input  logic                      sync,
  output logic [AUDIO_SAMPLE_W-1:0] peak
);

  logic [AUDIO_SAMPLE_W-1:0] mag;
  logic                      newmax;  // a new maximum landed since the last sync

  assign mag = abs_sat(sample);

  always_ff @(posedge clk12 or negedge reset12_) begin
    if (!reset12_) begin
      peak   <= '0;
      newmax <= 1'b0;
    end else begin
      if (sync) begin
        if (!newmax) peak <= peak - (peak >> 6);
        newmax <= 1'b0;
      end
      // a load in the sync cycle still counts for the frame that follows
      if (load && (mag > peak)) begin
        peak   <= mag;
        newmax <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_adc_rx.sv
// audio_adc_rx: WM8750 DSP-mode-B ADC receiver. Deserialises one left/right
// 16-bit pair per frame (MSB first, left then right) delimited by a one-cycle
// audio_adclrc pulse, and hands it to the consumer over valid/ready.
// Optional macro AUDIO_ADC_RX_PEAK_EN adds peak_left/peak_right meters.
//   clk12, reset12_            - 12.288 MHz clock (= BCLK), async active-low reset
//   audio_adclrc, audio_adcdat - frame sync and serial data, clk12 domain
//   sample_left/right/valid    - captured pair, held while valid && !ready
//   sample_ready               - consumer accept
//   locked                     - LOCK_FRAMES consecutive correct sync spacings
//   overrun, sync_err          - sticky error flags, cleared by err_clr
//   peak_left/right            - (macro only) unsigned peak magnitudes
module audio_adc_rx
  import audio_pkg::*;
#(
  parameter int FRAME_LEN   = AUDIO_FRAME_LEN,
  parameter int DATA_OFFSET = 1,   // 1..4
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk12,
  input  logic        reset12_,
  input  logic        audio_adclrc,
  input  logic        audio_adcdat,
  output logic [15:0] sample_left,
  output logic [15:0] sample_right,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        locked,
  output logic        overrun,
  output logic        sync_err,
  input  logic        err_clr
`ifdef AUDIO_ADC_RX_PEAK_EN
  ,
  output logic [15:0] peak_left,
  output logic [15:0] peak_right
`endif
);

  localparam int TIMEOUT = FRAME_LEN + 15;
  localparam int FCNT_W  = $clog2(TIMEOUT + 1);
  localparam int GOOD_W  = $clog2(LOCK_FRAMES + 1);

  audio_state_e      state;
  logic [FCNT_W-1:0] fcnt;      // cycles since the last sync, saturates at TIMEOUT
  logic [1:0]        delay;
  logic [4:0]        idx;
  logic [31:0]       shreg;
  audio_pair_t       pair;
  logic [GOOD_W-1:0] good_cnt;
  logic              have_ref;  // a previous sync exists to measure spacing against

  logic load, in_frame, spacing_ok, spacing_bad, abort_ev, overrun_ev;

  assign load        = (state == LOAD);
  assign in_frame    = (state == SKIP) || (state == SHIFT);
  assign spacing_ok  = (fcnt == FCNT_W'(FRAME_LEN - 1));
  assign spacing_bad = audio_adclrc && have_ref && !spacing_ok;
  assign abort_ev    = audio_adclrc && in_frame;
  assign overrun_ev  = load && sample_valid && !sample_ready;

  assign sample_left  = pair.left;
  assign sample_right = pair.right;

  always_ff @(posedge clk12 or negedge reset12_) begin
    if (!reset12_) begin
      state        <= IDLE;
      fcnt         <= '0;
      delay        <= '0;
      idx          <= '0;
      shreg        <= '0;
      pair         <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      overrun      <= 1'b0;
      sync_err     <= 1'b0;
      good_cnt     <= '0;
      have_ref     <= 1'b0;
    end else begin
      if (fcnt != FCNT_W'(TIMEOUT)) fcnt <= fcnt + 1'b1;

      // output handshake; a LOAD wins over the accept that would drop valid
      if (load) begin
        pair         <= shreg;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      // sticky flags: a new event beats err_clr in the same cycle
      if (overrun_ev)              overrun  <= 1'b1;
      else if (err_clr)            overrun  <= 1'b0;
      if (spacing_bad || abort_ev) sync_err <= 1'b1;
      else if (err_clr)            sync_err <= 1'b0;

      case (state)
        IDLE: ;
        // the cycle the countdown hits zero already samples the MSB, so
        // DATA_OFFSET=1 catches it on the cycle right after the sync
        SKIP: begin
          if (delay == 2'd0) begin
            shreg[31] <= audio_adcdat;
            idx       <= 5'd1;
            state     <= SHIFT;
          end else begin
            delay <= delay - 2'd1;
          end
        end
        SHIFT: begin
          shreg[5'd31 - idx] <= audio_adcdat;
          idx                <= idx + 5'd1;
          if (idx == 5'd31) state <= LOAD;
        end
        LOAD:    state <= WAIT;
        WAIT:    ;
        default: state <= IDLE;
      endcase

      // sync overrides whatever the FSM chose: a partial frame is dropped
      // and the new frame starts without a dead cycle
      if (audio_adclrc) begin
        fcnt     <= '0;
        have_ref <= 1'b1;
        state    <= SKIP;
        delay    <= 2'(DATA_OFFSET - 1);
        if (have_ref) begin
          if (spacing_ok) begin
            if (good_cnt >= GOOD_W'(LOCK_FRAMES - 1)) locked <= 1'b1;
            if (good_cnt != GOOD_W'(LOCK_FRAMES))     good_cnt <= good_cnt + 1'b1;
          end else begin
            locked   <= 1'b0;
            good_cnt <= '0;
          end
        end
      end else if (fcnt == FCNT_W'(TIMEOUT - 1)) begin
        // sync lost: next sync is treated as the first one again
        locked   <= 1'b0;
        have_ref <= 1'b0;
        good_cnt <= '0;
        state    <= IDLE;
      end
    end
  end

`ifdef AUDIO_ADC_RX_PEAK_EN
  audio_peak_meter u_peak_l (
    .clk12    (clk12),
    .reset12_ (reset12_),
    .load     (load),
    .sample   (shreg[31:16]),
    .sync     (audio_adclrc),
    .peak     (peak_left)
  );

  audio_peak_meter u_peak_r (
    .clk12    (clk12),
    .reset12_ (reset12_),
    .load     (load),
    .sample   (shreg[15:0]),
    .sync     (audio_adclrc),
    .peak     (peak_right)
  );
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
// tb_audio_adc_rx: scoreboard bench for audio_adc_rx. Two instances share sync,
// ready and err_clr: one with DATA_OFFSET=1, one with DATA_OFFSET=3, each fed
// its own serial line carrying the same words. Frames are pushed to a per-DUT
// expected queue when issued; monitors pop on every valid && ready.
module tb_audio_adc_rx;
  import audio_pkg::*;

  logic clk12 = 1'b0;
  logic reset12_ = 1'b0;
  logic lrc = 1'b0, dat = 1'b0, dat3 = 1'b0, err_clr = 1'b0;
  logic ready_fix = 1'b1, rand_mode = 1'b0, rnd_bit = 1'b1;
  logic sample_ready;
  logic [15:0] l1, r1, l3, r3;
  logic v1, lk1, ov1, se1, v3, lk3, ov3, se3;
`ifdef AUDIO_ADC_RX_PEAK_EN
  logic [15:0] pl1, pr1, pl3, pr3;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_q3[$];
  logic [31:0] e1, e3;

  assign sample_ready = rand_mode ? rnd_bit : ready_fix;

  always #5 clk12 = ~clk12;

  audio_adc_rx #(.DATA_OFFSET(1)) u_dut (
    .clk12(clk12), .reset12_(reset12_), .audio_adclrc(lrc), .audio_adcdat(dat),
    .sample_left(l1), .sample_right(r1), .sample_valid(v1), .sample_ready(sample_ready),
    .locked(lk1), .overrun(ov1), .sync_err(se1), .err_clr(err_clr)
`ifdef AUDIO_ADC_RX_PEAK_EN
    , .peak_left(pl1), .peak_right(pr1)
`endif
  );

  audio_adc_rx #(.DATA_OFFSET(3)) u_dut3 (
    .clk12(clk12), .reset12_(reset12_), .audio_adclrc(lrc), .audio_adcdat(dat3),
    .sample_left(l3), .sample_right(r3), .sample_valid(v3), .sample_ready(sample_ready),
    .locked(lk3), .overrun(ov3), .sync_err(se3), .err_clr(err_clr)
`ifdef AUDIO_ADC_RX_PEAK_EN
    , .peak_left(pl3), .peak_right(pr3)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic chk2(input string name, input logic [31:0] a1, input logic [31:0] a3,
                      input logic [31:0] exp);
    chk({name, " (offset1)"}, a1, exp);
    chk({name, " (offset3)"}, a3, exp);
  endtask

  task automatic wait_steps(input int n);
    repeat (n) @(posedge clk12);
    #2;
  endtask

  // One frame of len cycles: sync on step 0, word MSB first starting
  // DATA_OFFSET steps later. Model rule: a pair is delivered only if its 32 bits
  // finish before the next sync (offset 3 needs 35 cycles) and no reset hits.
  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int len,
                       input bit push, input int rst_at);
    logic [31:0] w;
    w = {l, r};
    if (push && len >= 35) begin
      exp_q.push_back(w);
      exp_q3.push_back(w);
    end
    for (int c = 0; c < len; c++) begin
      @(posedge clk12);
      #1;
      lrc  = (c == 0);
      dat  = (c >= 1 && c <= 32) ? w[32-c] : 1'b0;
      dat3 = (c >= 3 && c <= 34) ? w[34-c] : 1'b0;
      if (c == rst_at) begin
        #2 reset12_ = 1'b0;
        #1;
        chk2("async reset pair", {l1, r1}, {l3, r3}, 32'd0);
        chk2("async reset flags", {28'd0, v1, lk1, ov1, se1}, {28'd0, v3, lk3, ov3, se3}, 32'd0);
      end
      if (c == rst_at + 2) reset12_ = 1'b1;
    end
  endtask

  always @(posedge clk12) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  always @(negedge clk12) begin
    if (v1 && sample_ready) begin
      if (exp_q.size() == 0) chk("offset1 spurious pair", {31'd0, v1}, 32'd0);
      else begin
        e1 = exp_q.pop_front();
        chk("offset1 pair", {l1, r1}, e1);
      end
    end
    if (v3 && sample_ready) begin
      if (exp_q3.size() == 0) chk("offset3 spurious pair", {31'd0, v3}, 32'd0);
      else begin
        e3 = exp_q3.pop_front();
        chk("offset3 pair", {l3, r3}, e3);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] br;
    repeat (3) @(posedge clk12);
    #2;
    chk2("reset pair", {l1, r1}, {l3, r3}, 32'd0);
    chk2("reset flags", {28'd0, v1, lk1, ov1, se1}, {28'd0, v3, lk3, ov3, se3}, 32'd0);
`ifdef AUDIO_ADC_RX_PEAK_EN
    chk2("reset peak", {pl1, pr1}, {pl3, pr3}, 32'd0);
`endif
    @(posedge clk12);
    #1 reset12_ = 1'b1;

    // basic capture, ready tied high
    frame(16'h8001, 16'h7FFE, 256, 1, -1);
    fork
      frame(16'h8001, 16'h7FFE, 256, 1, -1);
      begin wait_steps(6); chk2("no lock after 2nd sync", lk1, lk3, 32'd0); end
    join
    fork
      frame(16'h8001, 16'h7FFE, 256, 1, -1);
      begin
        wait_steps(6);   chk2("lock after 3rd sync", lk1, lk3, 32'd1);
        wait_steps(194); chk2("basic sync_err", se1, se3, 32'd0);
      end
    join

    // backpressure: first pair is lost to the second
    ready_fix = 1'b0;
    br = 16'($urandom);
    fork
      frame(16'd1, 16'($urandom), 256, 0, -1);
      begin
        wait_steps(101);
        chk2("bp first pair shown", l1, l3, 32'd1);
        chk2("bp valid held", v1, v3, 32'd1);
      end
    join
    fork
      frame(16'd2, br, 256, 1, -1);
      begin
        wait_steps(21); chk2("bp pair stable", l1, l3, 32'd1);
        wait_steps(80);
        chk2("bp pair replaced", {l1, r1}, {l3, r3}, {16'd2, br});
        chk2("overrun set", ov1, ov3, 32'd1);
        ready_fix = 1'b1;
        wait_steps(10); err_clr = 1'b1;
        wait_steps(1);  err_clr = 1'b0;
        chk2("overrun cleared", ov1, ov3, 32'd0);
      end
    join

    // early sync mid-SHIFT
    frame(16'($urandom), 16'($urandom), 20, 1, -1);
    fork
      frame(16'($urandom), 16'($urandom), 256, 1, -1);
      begin
        wait_steps(6);
        chk2("early sync_err", se1, se3, 32'd1);
        chk2("early lock drop", lk1, lk3, 32'd0);
        wait_steps(5); err_clr = 1'b1;
        wait_steps(1); err_clr = 1'b0;
        chk2("sync_err cleared", se1, se3, 32'd0);
      end
    join

    // random data with random ready
    rand_mode = 1'b1;
    repeat (6) frame(16'($urandom), 16'($urandom), 256, 1, -1);
    rand_mode = 1'b0;
    ready_fix = 1'b1;
    chk2("relock after random", lk1, lk3, 32'd1);

    // reset mid-SHIFT, then recapture
    frame(16'($urandom), 16'($urandom), 256, 0, 15);
    for (int i = 0; i < 3; i++) frame(16'h1234, 16'($urandom), 256, 1, -1);
    chk2("relock after reset", lk1, lk3, 32'd1);

    // sync loss
    wait_steps(16); chk2("lock held at 270", lk1, lk3, 32'd1);
    wait_steps(1);  chk2("lock lost at 271", lk1, lk3, 32'd0);
    chk2("loss sync_err", se1, se3, 32'd0);
    chk2("loss back to IDLE", 32'(u_dut.state), 32'(u_dut3.state), 32'(IDLE));

`ifdef AUDIO_ADC_RX_PEAK_EN
    fork
      frame(16'h8000, 16'h0000, 256, 1, -1);
      begin wait_steps(101); chk2("peak saturates", pl1, pl3, 32'd32767); end
    join
    fork
      frame(16'h0000, 16'h0000, 256, 1, -1);
      begin wait_steps(101); chk2("peak held one frame", pl1, pl3, 32'd32767); end
    join
    fork
      frame(16'($urandom), 16'($urandom), 256, 1, -1);
      begin wait_steps(6); chk2("peak decay", pl1, pl3, 32'd32256); end
    join
`endif

    for (int i = 0; i < 1000 && (exp_q.size() != 0 || exp_q3.size() != 0); i++)
      @(posedge clk12);
    chk2("all pairs delivered", 32'(exp_q.size()), 32'(exp_q3.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/audio_adc_rx.md
Name: audio_adc_rx

Overview:
- Receive side of the WM8750 DSP-mode-B serial audio link; counterpart of the DAC transmitter on the same bus.
- Deserialises audio_adcdat into 16-bit signed left/right samples, one pair per frame.
- Frames are delimited by the one-cycle audio_adclrc pulse, with BCLK = MCLK = clk12.
- Presents each sample pair to the consumer (capture FIFO / loopback logic) through a valid/ready handshake, with lock and error status.

Parameters:
- FRAME_LEN, 256: clk12 cycles between audio_adclrc pulses (48 kHz-class frame).
- DATA_OFFSET, 1: cycles from the cycle audio_adclrc is sampled high to the cycle the left MSB is sampled (1..4).
- LOCK_FRAMES, 2: consecutive correctly spaced sync pulses required to assert locked.

Ports:
- clk12  in  1  12.288 MHz audio clock; also BCLK.
- reset12_  in  1  asynchronous active-low reset.
- audio_adclrc  in  1  frame sync, high for one cycle per frame, synchronous to clk12.
- audio_adcdat  in  1  serial ADC data, MSB first, left then right, synchronous to clk12.
- sample_left  out  16  captured left sample, signed two's complement.
- sample_right  out  16  captured right sample, signed two's complement.
- sample_valid  out  1  sample pair available.
- sample_ready  in  1  consumer accepts the pair when valid && ready.
- locked  out  1  frame timing stable.
- overrun  out  1  sticky: an unaccepted pair was overwritten.
- sync_err  out  1  sticky: sync arrived at the wrong spacing.
- err_clr  in  1  one-cycle pulse; clears overrun and sync_err.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; internal counters = 0.
- No input synchroniser; both serial inputs are in the clk12 domain.
- The FSM also keeps a free-running frame counter fcnt (9 bits, reset to 0 on every sync).
- FSM states:
  - IDLE: wait for audio_adclrc = 1; then go to SKIP with delay = DATA_OFFSET-1.
  - SKIP: count down the delay. When it reaches 0, go to SHIFT with bit index 0. With DATA_OFFSET = 1 the MSB is sampled on the cycle immediately after the sync.
  - SHIFT: sample audio_adcdat into shreg[31-idx] each cycle, for 32 cycles. After idx 31, go to LOAD.
  - LOAD (1 cycle): sample_left = shreg[31:16], sample_right = shreg[15:0]; sample_valid = 1; go to WAIT.
  - WAIT: remain here until the next sync, then go to SKIP.
- Data latency: the last right LSB is sampled at cycle S+DATA_OFFSET+31; sample_valid rises 2 cycles later.
- Sync spacing check, on every sync after the first since reset or since lock loss:
  - fcnt must equal FRAME_LEN-1.
  - Mismatch: set sync_err, clear locked, reset the good-frame count.
- Sync during SKIP or SHIFT:
  - Abort the partial frame (no LOAD) and set sync_err.
  - Restart at SKIP on the new sync; no extra dead cycle.
- Lost sync: if fcnt reaches FRAME_LEN+15 with no sync, clear locked and go to IDLE. sync_err is not set.
- locked:
  - Set after LOCK_FRAMES consecutive correct spacings.
  - Samples are delivered whether or not locked.
- Handshake:
  - The pair is held stable while sample_valid && !sample_ready.
  - Transfer happens on valid && ready; sample_valid drops the next cycle unless LOAD coincides.
  - LOAD while valid && !ready: overwrite the pair, keep valid = 1, set overrun.
  - LOAD in the same cycle as an accepting handshake: new pair, valid stays 1, no overrun.
- err_clr:
  - Clears the sticky flags.
  - If err_clr coincides with a new error event, the flag ends set (set wins).
- Reset mid-frame: immediate return to reset values; no partial sample is ever emitted.

Optional Feature:
- Macro: AUDIO_ADC_RX_PEAK_EN.
- When defined, adds outputs peak_left and peak_right, 16 bits unsigned, reset 0:
  - On each LOAD: peak = max(peak, |sample|), with |-32768| saturating to 32767.
  - Once per frame at sync, if no new max occurred: peak decays by peak>>6.
- When undefined: the ports are absent and no logic is generated.

Decomposition:
- Shared package audio_pkg holds:
  - the FSM state enum (IDLE, SKIP, SHIFT, LOAD, WAIT);
  - AUDIO_SAMPLE_W = 16 and AUDIO_FRAME_LEN = 256;
  - the sample-pair struct {left, right}.
- The transmitter should import the same constants.
- The optional peak logic is a natural sub-module, audio_peak_meter, instantiated twice (left, right) under the macro.

Test Plan:
- Basic capture: after reset, drive 3 frames (sync every 256 cycles) with left = 16'h8001, right = 16'h7FFE, MSB first, starting 1 cycle after sync. Expect:
  - 3 valid pulses with exactly those values, with ready tied 1;
  - locked = 1 after the 3rd sync;
  - sync_err = 0.
- Backpressure: ready = 0 across 2 frames (left = 1, then 2), then ready = 1. Expect:
  - the first pair held stable;
  - pair 1 is replaced by pair 2 at the second LOAD;
  - overrun = 1;
  - err_clr pulse then gives overrun = 0.
- Early sync: second sync at cycle 20 (mid-SHIFT). Expect:
  - no valid for the aborted frame;
  - sync_err = 1 and locked = 0;
  - the next frame is captured correctly.
- Sync loss: stop sync after lock. Expect locked = 0 at cycle 271 after the last sync, FSM back in IDLE, sync_err = 0.
- Offset and reset: with DATA_OFFSET = 3, left = 16'h1234 is captured correctly. Asserting reset12_ = 0 mid-SHIFT forces all outputs to 0 asynchronously; after release, no spurious valid occurs before the next full frame.
- Peak (macro on): samples -32768 then 0 give peak_left = 32767, then 32767 - 511 = 32256 after the next sync.
